digit_detector: RTL and testbench
=================================

Name: digit_detector

Overview:
- Downstream consumer of the network controller's output-layer results.
- On the controller's `network_done` pulse, scans the 10 output-neuron sigmoid values held at sigmoid-register addresses 8..17, one per cycle.
- Selects the arg-max as the recognised digit and holds the digit and its confidence for the SPI output side.
- Finishes well inside the controller's 255-cycle digit-wait window.

Parameters:
- NUM_CLASSES, 10, number of output neurons scanned.
- BASE_ADDR, 8, sigmoid-register address of output neuron 0.
- DATA_W, 4, sigmoid value width.
- ADDR_W, 5, sigmoid-register address width.
- MIN_CONF, 4, minimum winning value accepted (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- n_rst  in  1  reset; synchronous, active-high (asserted when 1).
- network_done  in  1  one-cycle pulse from the network controller: output layer written.
- sigmoidData_out  in  DATA_W  sigmoid register read data; combinational from sigmoid_read_address.
- sigmoid_read_en  out  1  high while the detector owns the sigmoid read port.
- sigmoid_read_address  out  ADDR_W  read address into the sigmoid registers.
- digit  out  4  recognised digit 0..9 (4'hF = rejected, only with the optional feature).
- confidence  out  DATA_W  winning sigmoid value.
- digit_valid  out  1  level; digit/confidence hold a valid result.
- digit_strobe  out  1  one-cycle pulse when a new result is posted.
- detect_busy  out  1  high while scanning.

Behaviour:
- Reset (n_rst=1 at a clock edge) forces all outputs and state to 0: state=IDLE, digit=0, confidence=0, digit_valid=0, digit_strobe=0, detect_busy=0, sigmoid_read_en=0, sigmoid_read_address=0. This applies at any time, including mid-scan; a partial scan is discarded.
- FSM states: IDLE, SCAN, POST.
- IDLE
  - Outputs held.
  - network_done=1 → SCAN: idx=0, best_val=0, best_idx=0, digit_valid cleared, digit_strobe=0.
- SCAN (NUM_CLASSES cycles, idx=0..9)
  - sigmoid_read_en=1, sigmoid_read_address=BASE_ADDR+idx (zero-extended to ADDR_W), detect_busy=1.
  - At the edge: if idx==0 or sigmoidData_out > best_val (strict unsigned compare), then best_val<=sigmoidData_out and best_idx<=idx.
  - Ties therefore resolve to the lowest index.
  - idx==NUM_CLASSES-1 → POST; otherwise idx<=idx+1.
- POST (1 cycle)
  - Registers digit<=best_idx, confidence<=best_val, digit_valid<=1, digit_strobe<=1 for exactly this one cycle.
  - Then → IDLE.
- Latency: network_done high in cycle 0 → SCAN in cycles 1..10 → digit_strobe in cycle 11 (strobe and digit_valid visible from cycle 12 with registered outputs; define both as registered, so both are first seen high in the same cycle, 12). Total 12 cycles, well below 255.
- network_done while in SCAN or POST is ignored; no restart and no queueing.
- network_done in the same cycle as the final POST→IDLE transition is also ignored. Only network_done sampled in IDLE starts a scan.
- digit_valid stays high until the next accepted network_done or reset.
- sigmoid_read_en=0 outside SCAN, so the controller owns the port; sigmoid_read_address=0 when not scanning.
- All-equal or all-zero inputs → digit=0, confidence=that value.
- Arithmetic: idx counter 4 bits, saturating never reached (terminal compare at NUM_CLASSES-1). Address add is done at ADDR_W with no overflow (max 17 < 32).

Optional Feature:
- Macro: DIGIT_THRESHOLD_EN.
- Defined: in POST, if best_val < MIN_CONF then digit<=4'hF (reject), confidence<=best_val, digit_valid<=1, digit_strobe<=1. Otherwise behaves as normal.
- Undefined: no threshold check; digit is always best_idx; MIN_CONF is unused.

Test Plan:
- Reset mid-scan: pulse network_done, assert n_rst on scan cycle 5 → next cycle all outputs 0, state IDLE; no strobe follows.
- Single winner: values 1,2,3,4,5,6,7,8,9,15 at addresses 8..17, pulse network_done → 12 cycles later digit=9, confidence=15, digit_valid=1, one-cycle digit_strobe; addresses 8..17 observed in order with sigmoid_read_en=1.
- Tie: value 12 at idx 3 and idx 7, others 0 → digit=3, confidence=12.
- All zero → digit=0, confidence=0, digit_valid=1.
- Re-trigger: second network_done during SCAN is ignored (exactly one strobe). A later network_done in IDLE drops digit_valid next cycle and posts the new result 12 cycles after the pulse.
- DIGIT_THRESHOLD_EN defined, MIN_CONF=4, max value 3 at idx 2 → digit=4'hF, confidence=3. With max 4 → digit=2.

Source files
------------

// File: rtl/digit_detector_if.sv
// Bundle between the network controller / sigmoid registers and the digit detector.
// The detector takes the slave modport; the controller side takes the master modport.
interface digit_detector_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
);
  logic              network_done;
  logic [DATA_W-1:0] sigmoidData_out;
  logic              sigmoid_read_en;
  logic [ADDR_W-1:0] sigmoid_read_address;
  logic [3:0]        digit;
  logic [DATA_W-1:0] confidence;
  logic              digit_valid;
  logic              digit_strobe;
  logic              detect_busy;

  modport master (
    output network_done, sigmoidData_out,
    input  sigmoid_read_en, sigmoid_read_address, digit, confidence,
           digit_valid, digit_strobe, detect_busy
  );

  modport slave (
    input  network_done, sigmoidData_out,
    output sigmoid_read_en, sigmoid_read_address, digit, confidence,
           digit_valid, digit_strobe, detect_busy
  );
endinterface

// File: rtl/digit_detector.sv
// Arg-max scan over the output-layer sigmoid registers after each network_done pulse.
// Optional reject threshold on the winning value: define DIGIT_THRESHOLD_EN.
module digit_detector #(
`ifdef DIGIT_THRESHOLD_EN
  parameter int MIN_CONF    = 4,
`endif
  parameter int NUM_CLASSES = 10,
  parameter int BASE_ADDR   = 8,
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  digit_detector_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    POST = 2'd2
  } state_e;

  localparam logic [3:0]        LAST_IDX  = 4'(NUM_CLASSES - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        digit_q, digit_d;
  logic [DATA_W-1:0] conf_q, conf_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              take_s;

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      best_val_q <= '0;
      best_idx_q <= 4'd0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      digit_q    <= 4'd0;
      conf_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      digit_q    <= digit_d;
      conf_q     <= conf_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.network_done) state_d = SCAN;
        else                  state_d = IDLE;
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = POST;
        else                   state_d = SCAN;
      end
      POST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict compare keeps the lowest index on ties; idx 0 always seeds the running max
  assign take_s = (idx_q == 4'd0) || (bus.sigmoidData_out > best_val_q);

  // Datapath and registered-output next values
  always_comb begin
    idx_d      = idx_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    digit_d    = digit_q;
    conf_d     = conf_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.network_done) begin
          idx_d      = 4'd0;
          best_val_d = '0;
          best_idx_d = 4'd0;
          valid_d    = 1'b0;
          rd_en_d    = 1'b1;
          rd_addr_d  = BASE_A;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      SCAN: begin
        if (take_s) begin
          best_val_d = bus.sigmoidData_out;
          best_idx_d = idx_q;
        end else begin
          best_val_d = best_val_q;
        end
        // Read port is handed back to the controller as soon as the last value is sampled
        if (idx_q == LAST_IDX) begin
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          busy_d    = 1'b0;
        end else begin
          idx_d     = idx_q + 4'd1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      POST: begin
`ifdef DIGIT_THRESHOLD_EN
        if (best_val_q < DATA_W'(MIN_CONF)) digit_d = 4'hF;
        else                                digit_d = best_idx_q;
`else
        digit_d  = best_idx_q;
`endif
        conf_d   = best_val_q;
        valid_d  = 1'b1;
        strobe_d = 1'b1;
      end
      default: begin
        strobe_d = 1'b0;
      end
    endcase
  end

  assign bus.sigmoid_read_en      = rd_en_q;
  assign bus.sigmoid_read_address = rd_addr_q;
  assign bus.digit                = digit_q;
  assign bus.confidence           = conf_q;
  assign bus.digit_valid          = valid_q;
  assign bus.digit_strobe         = strobe_q;
  assign bus.detect_busy          = busy_q;

endmodule

// File: tb/tb_digit_detector.sv
// Self-checking bench for digit_detector: directed scenarios plus randomized arg-max runs
// compared against a loop-based arg-max reference model.
module tb_digit_detector;

  logic clk;
  logic n_rst;
  logic [3:0] mem [0:31];

  int n_cmp;
  int n_fail;

  logic       en_log    [0:41];
  logic [4:0] addr_log  [0:41];
  logic       valid_log [0:41];
  logic       busy_log  [0:41];

  digit_detector_if bif ();

  digit_detector dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bif.slave)
  );

  assign bif.sigmoidData_out = mem[bif.sigmoid_read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arg-max by plain iteration over the class values; first maximum wins
  function automatic void ref_model(output logic [3:0] d, output logic [3:0] c);
    int b;
    b = 0;
    for (int i = 1; i < 10; i++) begin
      if (mem[8 + i] > mem[8 + b]) b = i;
    end
    c = mem[8 + b];
    d = 4'(b);
`ifdef DIGIT_THRESHOLD_EN
    if (c < 4'd4) d = 4'hF;
`endif
  endfunction

  // Pulse network_done, optionally re-pulse after `extra` ticks, run 40 more cycles
  task automatic do_scan(input int extra, output int first_strobe, output int n_strobe);
    first_strobe = -1;
    n_strobe     = 0;
    bif.network_done = 1'b1;
    tick();
    en_log[1] = bif.sigmoid_read_en; addr_log[1] = bif.sigmoid_read_address;
    valid_log[1] = bif.digit_valid;  busy_log[1] = bif.detect_busy;
    for (int c = 1; c <= 40; c++) begin
      bif.network_done = (c == extra);
      tick();
      en_log[c+1]    = bif.sigmoid_read_en;
      addr_log[c+1]  = bif.sigmoid_read_address;
      valid_log[c+1] = bif.digit_valid;
      busy_log[c+1]  = bif.detect_busy;
      if (bif.digit_strobe) begin
        n_strobe++;
        if (first_strobe < 0) first_strobe = c + 1;
      end
    end
    bif.network_done = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    bif.network_done = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bif.digit, bif.confidence, bif.digit_valid, bif.digit_strobe, bif.detect_busy,
         bif.sigmoid_read_en, bif.sigmoid_read_address} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got digit=%h conf=%h valid=%b strobe=%b busy=%b en=%b addr=%0d, want all 0",
               bif.digit, bif.confidence, bif.digit_valid, bif.digit_strobe, bif.detect_busy,
               bif.sigmoid_read_en, bif.sigmoid_read_address);
    end
    n_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_winner();
    int fs, ns;
    bit addr_ok;
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'(i + 1);
    mem[17] = 4'd15;
    do_scan(0, fs, ns);
    addr_ok = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      if (en_log[j] !== 1'b1 || addr_log[j] !== 5'(7 + j) || busy_log[j] !== 1'b1) addr_ok = 1'b0;
    end
    if (en_log[11] !== 1'b0 || addr_log[11] !== 5'd0 || busy_log[11] !== 1'b0) addr_ok = 1'b0;
    n_cmp++;
    if (!addr_ok) begin
      n_fail++;
      $display("FAIL scan_addresses: got en/addr sequence not 8..17 with en=1 then released, want 8..17");
    end
    n_cmp++;
    if (fs !== 12 || ns !== 1) begin
      n_fail++;
      $display("FAIL single_latency: got first strobe %0d count %0d, want 12 and 1", fs, ns);
    end
    n_cmp++;
    if (bif.digit !== 4'd9 || bif.confidence !== 4'd15 || bif.digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: got digit=%h conf=%h valid=%b, want 9 15 1",
               bif.digit, bif.confidence, bif.digit_valid);
    end
  endtask

  task automatic test_tie_and_zero();
    int fs, ns;
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'd0;
    mem[8 + 3] = 4'd12;
    mem[8 + 7] = 4'd12;
    do_scan(0, fs, ns);
    n_cmp++;
    if (bif.digit !== 4'd3 || bif.confidence !== 4'd12) begin
      n_fail++;
      $display("FAIL tie_result: got digit=%h conf=%h, want 3 12", bif.digit, bif.confidence);
    end
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'd0;
    do_scan(0, fs, ns);
    n_cmp++;
    if (bif.digit !== 4'd0 || bif.confidence !== 4'd0 || bif.digit_valid !== 1'b1 || ns !== 1) begin
`ifdef DIGIT_THRESHOLD_EN
      if (!(bif.digit === 4'hF && bif.confidence === 4'd0 && bif.digit_valid === 1'b1 && ns == 1)) begin
        n_fail++;
        $display("FAIL zero_result: got digit=%h conf=%h valid=%b, want F 0 1", bif.digit, bif.confidence, bif.digit_valid);
      end
`else
      n_fail++;
      $display("FAIL zero_result: got digit=%h conf=%h valid=%b strobes=%0d, want 0 0 1 1",
               bif.digit, bif.confidence, bif.digit_valid, ns);
`endif
    end
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'd9;
    do_scan(0, fs, ns);
    n_cmp++;
    if (bif.digit !== 4'd0 || bif.confidence !== 4'd9) begin
      n_fail++;
      $display("FAIL equal_result: got digit=%h conf=%h, want 0 9", bif.digit, bif.confidence);
    end
  endtask

  task automatic test_retrigger();
    int fs, ns;
    logic [3:0] ed, ec;
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'($urandom_range(15, 0));
    ref_model(ed, ec);
    do_scan(5, fs, ns);
    n_cmp++;
    if (ns !== 1 || fs !== 12 || bif.detect_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retrig_scan: got strobes %0d first %0d busy %b, want 1 12 0", ns, fs, bif.detect_busy);
    end
    do_scan(11, fs, ns);
    n_cmp++;
    if (ns !== 1 || bif.detect_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retrig_post: got strobes %0d busy %b, want 1 0", ns, bif.detect_busy);
    end
    n_cmp++;
    if (valid_log[1] !== 1'b0 || valid_log[11] !== 1'b0 || valid_log[12] !== 1'b1 || fs !== 12) begin
      n_fail++;
      $display("FAIL valid_drop: got valid@1=%b @11=%b @12=%b first %0d, want 0 0 1 12",
               valid_log[1], valid_log[11], valid_log[12], fs);
    end
    n_cmp++;
    if (bif.digit !== ed || bif.confidence !== ec) begin
      n_fail++;
      $display("FAIL retrig_result: got digit=%h conf=%h, want %h %h", bif.digit, bif.confidence, ed, ec);
    end
  endtask

  task automatic test_reset_mid_scan();
    int ns;
    logic [3:0] pd, pc;
    pd = bif.digit;
    pc = bif.confidence;
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'd7;
    bif.network_done = 1'b1;
    tick();
    bif.network_done = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    n_cmp++;
    if ({bif.digit, bif.confidence, bif.digit_valid, bif.digit_strobe, bif.detect_busy,
         bif.sigmoid_read_en, bif.sigmoid_read_address} !== 19'd0) begin
      n_fail++;
      $display("FAIL midscan_reset: got digit=%h conf=%h valid=%b busy=%b en=%b addr=%0d (prev %h/%h), want all 0",
               bif.digit, bif.confidence, bif.digit_valid, bif.detect_busy,
               bif.sigmoid_read_en, bif.sigmoid_read_address, pd, pc);
    end
    ns = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bif.digit_strobe || bif.detect_busy) ns++;
    end
    n_cmp++;
    if (ns !== 0) begin
      n_fail++;
      $display("FAIL midscan_nostrobe: got %0d strobe/busy cycles, want 0", ns);
    end
  endtask

  task automatic test_random();
    int fs, ns;
    logic [3:0] ed, ec;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 10; i++) begin
        if (r % 3 == 0) mem[8 + i] = 4'($urandom_range(3, 0));
        else            mem[8 + i] = 4'($urandom_range(15, 0));
      end
      for (int a = 0; a < 8; a++) mem[a] = 4'hF;
      ref_model(ed, ec);
      do_scan(0, fs, ns);
      n_cmp++;
      if (bif.digit !== ed || bif.confidence !== ec || bif.digit_valid !== 1'b1 || ns !== 1 || fs !== 12) begin
        n_fail++;
        $display("FAIL random_%0d: got digit=%h conf=%h valid=%b strobes=%0d first=%0d, want %h %h 1 1 12",
                 r, bif.digit, bif.confidence, bif.digit_valid, ns, fs, ed, ec);
      end
    end
  endtask

`ifdef DIGIT_THRESHOLD_EN
  task automatic test_threshold();
    int fs, ns;
    for (int i = 0; i < 10; i++) mem[8 + i] = 4'd1;
    mem[8 + 2] = 4'd3;
    do_scan(0, fs, ns);
    n_cmp++;
    if (bif.digit !== 4'hF || bif.confidence !== 4'd3 || bif.digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL thresh_reject: got digit=%h conf=%h, want F 3", bif.digit, bif.confidence);
    end
    mem[8 + 2] = 4'd4;
    do_scan(0, fs, ns);
    n_cmp++;
    if (bif.digit !== 4'd2 || bif.confidence !== 4'd4) begin
      n_fail++;
      $display("FAIL thresh_accept: got digit=%h conf=%h, want 2 4", bif.digit, bif.confidence);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bif.network_done = 1'b0;
    n_rst = 1'b1;
    for (int a = 0; a < 32; a++) mem[a] = 4'($urandom_range(15, 0));
    test_reset();
    test_single_winner();
    test_tie_and_zero();
    test_retrigger();
    test_reset_mid_scan();
    test_random();
`ifdef DIGIT_THRESHOLD_EN
    test_threshold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
